writeback_stage: RTL and testbench

Final stage of the pipelined processor, directly downstream of the memory access stage. Captures the 64-bit writeback value (load data or ALU result) with its destination register in a one-entry MEM/WB latch, commits it to a 32 x 64-bit register file, and counts retired instructions. Provides two read ports to decode with write-through bypass, and a forwarding tap for execute.

---
 rtl/writeback_stage.sv | 98 +++++++++
 tb/tb_writeback_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: one-entry MEM/WB latch, register file commit, retire counter,
// plus decode read ports with write-through bypass and an execute forwarding tap.
module writeback_stage #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_reg_write,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              vld_p1;
    logic              we_p1;
    logic [AW-1:0]     rd_p1;
    logic [DATA_W-1:0] data_p1;
    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  retire_cnt;
    logic              accept;
    logic              commit;

    // Register 0 is hardwired to zero; a pending write to the same index wins over the array.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     addr,
        input logic [DATA_W-1:0] arr_val,
        input logic              pend_vld,
        input logic              pend_we,
        input logic [AW-1:0]     pend_rd,
        input logic [DATA_W-1:0] pend_data
    );
        if (addr == '0)
            return '0;
        else if (pend_vld && pend_we && (pend_rd == addr))
            return pend_data;
        else
            return arr_val;
    endfunction

    assign accept   = in_valid && !hold;
    assign commit   = vld_p1 && !hold;
    assign in_ready = !hold;

    // Stage boundary: MEM -> WB latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            we_p1   <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            we_p1   <= in_reg_write;
            rd_p1   <= in_rd;
            data_p1 <= in_data;
        end else if (commit) begin
            vld_p1  <= 1'b0;
        end
    end

    // Stage boundary: WB latch -> architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (commit && we_p1 && (rd_p1 != '0)) begin
            regs[rd_p1] <= data_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (commit)
            retire_cnt <= retire_cnt + CNT_W'(1);
    end

    assign rd_data_a    = read_port(rd_addr_a, regs[rd_addr_a], vld_p1, we_p1, rd_p1, data_p1);
    assign rd_data_b    = read_port(rd_addr_b, regs[rd_addr_b], vld_p1, we_p1, rd_p1, data_p1);
    assign fwd_valid    = vld_p1 && we_p1 && (rd_p1 != '0);
    assign fwd_rd       = rd_p1;
    assign fwd_data     = data_p1;
    assign retire_count = retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; counter narrowed to 4 bits so wrap is reachable.
module tb_writeback_stage;

    localparam int DATA_W = 64;
    localparam int AW     = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rd;
    logic              in_reg_write;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic [AW-1:0]     rd_addr_a;
    logic [AW-1:0]     rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              fwd_valid;
    logic [AW-1:0]     fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  retire_count;

    int total = 0;
    int bad   = 0;

    writeback_stage #(.DATA_W(DATA_W), .NREG(32), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_data(in_data), .hold(hold),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic we,
                         input logic [DATA_W-1:0] d);
        in_valid = v; in_rd = rd; in_reg_write = we; in_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0;
        drive(1'b1, 5'd17, 1'b1, 64'hA5A5_5A5A_1234_5678);
        rd_addr_a = 5'd5; rd_addr_b = 5'd31;
        #2;
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd_valid got=%0d want=0", fwd_valid); end
        total++; if (fwd_rd !== 5'd0) begin bad++; $display("FAIL reset_fwd_rd got=%0d want=0", fwd_rd); end
        total++; if (fwd_data !== 64'd0) begin bad++; $display("FAIL reset_fwd_data got=%h want=0", fwd_data); end
        total++; if (rd_data_a !== 64'd0) begin bad++; $display("FAIL reset_rd_a got=%h want=0", rd_data_a); end
        total++; if (rd_data_b !== 64'd0) begin bad++; $display("FAIL reset_rd_b got=%h want=0", rd_data_b); end
        total++; if (retire_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", retire_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0d want=1", in_ready); end
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        rd_addr_a = 5'd3;
        drive(1'b1, 5'd3, 1'b1, 64'hDEAD_BEEF_0000_0001);
        tick();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        total++; if (fwd_valid !== 1'b1) begin bad++; $display("FAIL single_fwd_valid got=%0d want=1", fwd_valid); end
        total++; if (fwd_rd !== 5'd3) begin bad++; $display("FAIL single_fwd_rd got=%0d want=3", fwd_rd); end
        total++; if (fwd_data !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL single_fwd_data got=%h want=deadbeef00000001", fwd_data); end
        total++; if (rd_data_a !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL single_bypass got=%h want=deadbeef00000001", rd_data_a); end
        total++; if (retire_count !== 4'd0) begin bad++; $display("FAIL single_count_pre got=%0d want=0", retire_count); end
        tick();
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL single_fwd_after got=%0d want=0", fwd_valid); end
        total++; if (rd_data_a !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL single_regfile got=%h want=deadbeef00000001", rd_data_a); end
        total++; if (retire_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d want=1", retire_count); end
    endtask

    task automatic test_back_to_back();
        rd_addr_a = 5'd7;
        drive(1'b1, 5'd7, 1'b1, 64'h11);
        tick();
        total++; if (rd_data_a !== 64'h11) begin bad++; $display("FAIL b2b_first got=%h want=11", rd_data_a); end
        drive(1'b1, 5'd7, 1'b1, 64'h22);
        tick();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        total++; if (rd_data_a !== 64'h22) begin bad++; $display("FAIL b2b_second got=%h want=22", rd_data_a); end
        total++; if (retire_count !== 4'd2) begin bad++; $display("FAIL b2b_count_mid got=%0d want=2", retire_count); end
        tick();
        total++; if (rd_data_a !== 64'h22) begin bad++; $display("FAIL b2b_regfile got=%h want=22", rd_data_a); end
        total++; if (retire_count !== 4'd3) begin bad++; $display("FAIL b2b_count got=%0d want=3", retire_count); end
    endtask

    task automatic test_reg0_nowrite();
        rd_addr_a = 5'd0; rd_addr_b = 5'd4;
        drive(1'b1, 5'd0, 1'b1, 64'hFF);
        tick();
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL r0_fwd_valid got=%0d want=0", fwd_valid); end
        total++; if (rd_data_a !== 64'd0) begin bad++; $display("FAIL r0_bypass got=%h want=0", rd_data_a); end
        drive(1'b1, 5'd4, 1'b0, 64'hAB);
        tick();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL nowe_fwd_valid got=%0d want=0", fwd_valid); end
        total++; if (rd_data_b !== 64'd0) begin bad++; $display("FAIL nowe_bypass got=%h want=0", rd_data_b); end
        tick();
        total++; if (rd_data_a !== 64'd0) begin bad++; $display("FAIL r0_regfile got=%h want=0", rd_data_a); end
        total++; if (rd_data_b !== 64'd0) begin bad++; $display("FAIL nowe_regfile got=%h want=0", rd_data_b); end
        total++; if (retire_count !== 4'd5) begin bad++; $display("FAIL r0_count got=%0d want=5", retire_count); end
    endtask

    task automatic test_hold();
        rd_addr_a = 5'd9; rd_addr_b = 5'd10;
        drive(1'b1, 5'd9, 1'b1, 64'h55);
        tick();
        hold = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 64'h66);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%0d want=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rd_data_a !== 64'h55) begin bad++; $display("FAIL hold_bypass[%0d] got=%h want=55", i, rd_data_a); end
            total++; if (fwd_rd !== 5'd9) begin bad++; $display("FAIL hold_fwd_rd[%0d] got=%0d want=9", i, fwd_rd); end
            total++; if (retire_count !== 4'd5) begin bad++; $display("FAIL hold_count[%0d] got=%0d want=5", i, retire_count); end
            total++; if (rd_data_b !== 64'd0) begin bad++; $display("FAIL hold_no_accept[%0d] got=%h want=0", i, rd_data_b); end
        end
        hold = 1'b0;
        tick();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        total++; if (fwd_rd !== 5'd10 || fwd_data !== 64'h66) begin bad++; $display("FAIL release_accept got=%0d/%h want=10/66", fwd_rd, fwd_data); end
        total++; if (rd_data_a !== 64'h55) begin bad++; $display("FAIL release_regfile got=%h want=55", rd_data_a); end
        total++; if (retire_count !== 4'd6) begin bad++; $display("FAIL release_count got=%0d want=6", retire_count); end
        tick();
        total++; if (rd_data_b !== 64'h66) begin bad++; $display("FAIL release_second got=%h want=66", rd_data_b); end
        total++; if (retire_count !== 4'd7) begin bad++; $display("FAIL release_count2 got=%0d want=7", retire_count); end
    endtask

    task automatic test_wrap_async_reset();
        #3 rst_n = 1'b0;
        #1;
        total++; if (retire_count !== 4'd0 || rd_data_a !== 64'd0) begin bad++; $display("FAIL areset_clear got=%0d/%h want=0/0", retire_count, rd_data_a); end
        #2 rst_n = 1'b1;
        rd_addr_a = 5'd20;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd20, 1'b1, 64'(i));
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        tick();
        total++; if (retire_count !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", retire_count); end
        total++; if (rd_data_a !== 64'd16) begin bad++; $display("FAIL wrap_last got=%0d want=16", rd_data_a); end
        rd_addr_a = 5'd12;
        drive(1'b1, 5'd12, 1'b1, 64'h77);
        tick();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        total++; if (fwd_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%0d want=1", fwd_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (fwd_valid !== 1'b0 || fwd_data !== 64'd0 || fwd_rd !== 5'd0) begin bad++; $display("FAIL mid_reset_fwd got=%0d/%0d/%h want=0/0/0", fwd_valid, fwd_rd, fwd_data); end
        total++; if (rd_data_a !== 64'd0 || retire_count !== 4'd0) begin bad++; $display("FAIL mid_reset_state got=%h/%0d want=0/0", rd_data_a, retire_count); end
        #2 rst_n = 1'b1;
        tick();
        total++; if (rd_data_a !== 64'd0 || retire_count !== 4'd0) begin bad++; $display("FAIL mid_reset_nocommit got=%h/%0d want=0/0", rd_data_a, retire_count); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_reg0_nowrite();
        test_hold();
        test_wrap_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
